// File: rtl/eg2000_video_pkg.sv
// eg2000_video_pkg: shared constants for the eg2000 video output stage.
//   RGB_W      - bits per colour channel
//   MONO_GREEN - green level of the monochrome phosphor build
//   PALETTE    - 16-entry 24-bit RGB palette, entry n at PALETTE[n]
package eg2000_video_pkg;
    localparam int RGB_W = 8;
    localparam logic [RGB_W-1:0] MONO_GREEN = 8'hE0;
    localparam logic [15:0][23:0] PALETTE = {
        24'hFFFFFF, 24'hFFFF55, 24'hFF55FF, 24'hFF5555,
        24'h55FFFF, 24'h55FF55, 24'h5555FF, 24'h555555,
        24'hAAAAAA, 24'hAA5500, 24'hAA00AA, 24'hAA0000,
        24'h00AAAA, 24'h00AA00, 24'h0000AA, 24'h000000
    };
endpackage

// File: rtl/eg2000_sync_meter.sv
// eg2000_sync_meter: measures line length and frame height from the stage-1 syncs.
//   clock, reset (async, active-high), ce_pix - timing
//   hsync, vsync                              - stage-1 syncs, active-high
//   line_len, frame_lines                     - last measured strobes/line, lines/frame
//   stable                                    - two consecutive frames with the same mode
module eg2000_sync_meter #(
    parameter int CNT_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             hsync,
    input  logic             vsync,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             stable
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic hs_q, vs_q, h_rise, v_rise, prev_valid;
    logic [CNT_W-1:0] hcnt, vcnt, prev_len, prev_lines, len_nxt, vcnt_inc;
    always_comb begin
        h_rise = hsync && !hs_q;
        v_rise = vsync && !vs_q;
        // the edge strobe itself belongs to the line that is ending
        len_nxt = h_rise ? ((hcnt == MAX) ? MAX : hcnt + ONE) : line_len;
        // a line starting on the vsync strobe is counted into the closing frame
        vcnt_inc = (h_rise && vcnt != MAX) ? vcnt + ONE : vcnt;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            prev_len    <= '0;
            prev_lines  <= '0;
            prev_valid  <= 1'b0;
            stable      <= 1'b0;
        end else if (ce_pix) begin
            hs_q     <= hsync;
            vs_q     <= vsync;
            hcnt     <= h_rise ? '0 : ((hcnt == MAX) ? MAX : hcnt + ONE);
            line_len <= len_nxt;
            vcnt     <= v_rise ? '0 : vcnt_inc;
            if (v_rise) begin
                frame_lines <= vcnt_inc;
                prev_len    <= len_nxt;
                prev_lines  <= vcnt_inc;
                prev_valid  <= 1'b1;
                stable      <= prev_valid && len_nxt == prev_len && vcnt_inc == prev_lines
                               && len_nxt != '0 && len_nxt != MAX;
            end
        end
    end
endmodule

// File: rtl/eg2000_video_out.sv
// eg2000_video_out: two-stage pixel pipeline, palette lookup, aligned sync/blank and sync meter.
//   clock, reset (async, active-high), ce_pix - timing; state advances only on ce_pix
//   pixel, color, de, hsync_in, vsync_in      - core/CRTC video inputs
//   r, g, b, hs, vs, hblank, vblank           - video outputs, 2 strobes after input
//   line_len, frame_lines, stable             - sync meter results
// Build option: define EG2000_VIDEO_MONO_EN for the green-phosphor (palette bypassed) build.
module eg2000_video_out
    import eg2000_video_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             pixel,
    input  logic [3:0]       color,
    input  logic             de,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [RGB_W-1:0] r,
    output logic [RGB_W-1:0] g,
    output logic [RGB_W-1:0] b,
    output logic             hs,
    output logic             vs,
    output logic             hblank,
    output logic             vblank,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             stable
);
    logic pix1, de1, hs1, vs1;
    logic [3:0] col1;
    logic [3*RGB_W-1:0] rgb_nxt;
    always_comb begin
`ifdef EG2000_VIDEO_MONO_EN
        rgb_nxt = (de1 && pix1) ? {8'h00, MONO_GREEN, 8'h00} : '0;
`else
        rgb_nxt = de1 ? PALETTE[pix1 ? col1 : 4'd0] : '0;
`endif
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix1   <= 1'b0;
            col1   <= '0;
            de1    <= 1'b0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
            hs     <= 1'b0;
            vs     <= 1'b0;
            hblank <= 1'b1;
            vblank <= 1'b1;
        end else if (ce_pix) begin
            pix1        <= pixel;
            col1        <= color;
            de1         <= de;
            hs1         <= hsync_in;
            vs1         <= vsync_in;
            {r, g, b}   <= rgb_nxt;
            hs          <= hs1;
            vs          <= vs1;
            hblank      <= !de1;
            // vs holds the previous stage-1 vsync, so vs1 && !vs is its rising edge
            if (vs1 && !vs)
                vblank <= 1'b1;
            else if (de1)
                vblank <= 1'b0;
        end
    end
    eg2000_sync_meter #(.CNT_W(CNT_W)) u_meter (
        .clock      (clock),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .hsync      (hs1),
        .vsync      (vs1),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .stable     (stable)
    );
endmodule

// File: doc/eg2000_video_out.md
# eg2000_video_out

Pixel-rate video output stage that sits directly downstream of the eg2000 core. It consumes the core's `pixel`/`color[3:0]` stream, CRTC `de`, `hsync` and `vsync`, and produces 24-bit RGB through a 16-entry palette. It also produces aligned sync and blank signals for the framework scaler. A sync meter measures line length and frame height, and flags a stable video mode for on-screen display and scaler setup.

## Interface
Parameters:
- `CNT_W`, default 10: width of the measurement counters and results; counters saturate at 2^CNT_W−1.

Ports:
- `clock` in 1: system clock, same clock as the core.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ce_pix` in 1: pixel strobe (8.8 MHz enable); all video state advances only when high.
- `pixel` in 1: foreground pixel from the core.
- `color` in 4: palette index of the foreground.
- `de` in 1: CRTC display enable.
- `hsync_in` in 1: CRTC horizontal sync, active-high.
- `vsync_in` in 1: CRTC vertical sync, active-high.
- `r`, `g`, `b` out 8 each: pixel colour.
- `hs`, `vs` out 1 each: aligned sync outputs, active-high.
- `hblank`, `vblank` out 1 each: aligned blank outputs.
- `line_len` out CNT_W: ce_pix strobes per line, last measured.
- `frame_lines` out CNT_W: lines per frame, last measured.
- `stable` out 1: mode stable for two consecutive frames.

## Operation
- Stage 1, on `ce_pix`, registers the inputs `pixel`, `color`, `de`, `hsync_in` and `vsync_in`.
- Stage 2, on `ce_pix`, computes the outputs from stage 1:
  - Colour index is `color` if `pixel`, else 0.
  - RGB is `PALETTE[index]` if `de`, else 24'h000000.
  - `hs`/`vs` are the stage-1 syncs.
  - `hblank` = !de.
- `vblank` behaviour:
  - Set on the stage-1 vsync rising edge.
  - Cleared on the first stage-1 `de`=1 that follows.
  - While `vblank`=1, `hblank` still follows !de.
- Edge detection compares stage-1 sync against its previous value, sampled on `ce_pix` only.
- Sync meter, line counter:
  - `hcnt` increments on every `ce_pix`.
  - On a hsync rising edge, `line_len` ← `hcnt`+1 (the edge strobe is counted as part of the previous line) and `hcnt` ← 0.
  - `hcnt` saturates at max and does not wrap.
- Sync meter, frame counter:
  - `vcnt` increments on each hsync rising edge.
  - On a vsync rising edge, `frame_lines` ← `vcnt` and `vcnt` ← 0.
  - If hsync and vsync rise on the same strobe, the vsync capture uses `vcnt` including that line, then `vcnt` ← 0.
  - Saturation as for `hcnt`.
- `stable` behaviour:
  - On each vsync rising edge, compare the new (`line_len`, `frame_lines`) with the pair captured at the previous vsync edge.
  - Equal → `stable`=1; unequal → `stable`=0.
  - The first vsync after reset always gives 0.
  - A `line_len` of 0 or max (saturated) forces 0.

## Timing
- Video latency is exactly 2 `ce_pix` strobes, input to output. RGB, hs, vs, hblank and vblank stay mutually aligned.
- Outputs change only on a `clock` edge where `ce_pix`=1, and hold otherwise.
- Measurement outputs update on the strobe that detects the edge, 1 strobe after the input rises.
- Reset values:
  - r, g, b = 0; hs = vs = 0; hblank = vblank = 1.
  - line_len = frame_lines = 0; stable = 0.
  - Pipeline regs 0; hcnt = vcnt = 0.
- Reset mid-frame clears the meter. `stable` needs two full frames after release.

## Configuration
- `EG2000_VIDEO_MONO_EN` defined: palette bypassed.
  - If `de`&&`pixel`: r = 8'h00, g = 8'hE0, b = 8'h00 (green phosphor).
  - Otherwise: RGB = 0.
  - `color` is ignored.
- Not defined: full 16-colour palette path as above.
- Sync, blank, latency and meter are identical in both builds.

## Structure
- Package `eg2000_video_pkg`:
  - `PALETTE`: 16×24-bit constant, with 0=000000, 2=00AA00, 4=AA0000, 15=FFFFFF.
  - `RGB_W`=8.
  - `MONO_GREEN`=8'hE0.
- Sub-module `eg2000_sync_meter` holds hcnt, vcnt, the captures and `stable`. It takes the stage-1 syncs and `ce_pix`.
- The top holds the pipeline and palette.

## Test plan
- Reset asserted mid-stream → all outputs take their reset values immediately, asynchronously. After release, video appears 2 strobes after the first driven input.
- `de`=1, `pixel`=1, `color`=4 → `r`,`g`,`b` = AA,00,00 two strobes later. Then `pixel`=0 → 00,00,00. Then `de`=0 → 0, with hblank=1 on the same strobe.
- 564-strobe lines, 312 lines per frame, for 3 frames → `line_len`=564 and `frame_lines`=312. `stable` is 0 after the 1st vsync edge and 1 after the 2nd.
- Change to 312 → 262 lines → `stable` drops at the next vsync edge and returns 1 after two 262-line frames.
- No hsync edge for 1500 strobes → `hcnt` saturates at 1023 and `line_len`=1023 at the next edge; `stable`=0. Also: hsync and vsync rising together → vsync capture includes that line.
- `EG2000_VIDEO_MONO_EN` build: `color`=4, `pixel`=1, `de`=1 → 00,E0,00; latency is still 2 strobes.
